fixed_point_stream_dot: RTL and testbench
=========================================

Name: fixed_point_stream_dot

Overview:
- Parametrised, fully pipelined signed fixed-point dot product of two N-element vectors.
- Valid/ready streaming interface at input and output, with backpressure.
- Selectable rounding (truncate or round-half-up) and optional output saturation.
- Feeds the geometry/shading datapath wherever vector projections and normals are evaluated in a streamed, stall-tolerant pipeline.

Parameters:
- N, 3, number of vector elements (lanes); N >= 1.
- A_WIDTH, 16, width of each A element (signed).
- A_FRAC_BITS, 14, fractional bits of A.
- B_WIDTH, 16, width of each B element (signed).
- B_FRAC_BITS, 14, fractional bits of B.
- P_FRAC_BITS, 14, fractional bits of result; must be <= A_FRAC_BITS + B_FRAC_BITS.
- D_WIDTH, 18, output width (signed).
- ROUND_MODE, 0, 0 = truncate (arithmetic shift, floor), 1 = round half up.
- SATURATE, 1, 1 = clamp to D_WIDTH range, 0 = keep low D_WIDTH bits (wrap).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- in_valid  in  1  A/B vectors valid.
- in_ready  out  1  block accepts the vectors this cycle.
- in_a  in  N x A_WIDTH  packed signed vector; element i at [i].
- in_b  in  N x B_WIDTH  packed signed vector.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  D_WIDTH  signed result, P_FRAC_BITS fractional bits.

Behaviour:
- Reset is asynchronous, active-low. While rst_n_in = 0, all stage valid bits, out_valid and out_data are 0 immediately, with no clock edge required. Data registers also clear to 0.
- Derived constants:
  - PW = A_WIDTH + B_WIDTH.
  - L = $clog2(N); L = 0 when N = 1.
  - SW = PW + L.
  - E = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS.
- Pipeline stages:
  - S0 registers the inputs.
  - S1 registers N full-width signed products (PW bits).
  - S2 .. S(1+L) form a binary adder tree. Each level registers the sums of pairs, sign-extended by 1 bit; an odd leftover passes through registered. The tree is lossless to SW bits.
  - Final stage: round, shift by E, saturate/wrap, register into out_data.
- Latency: 3 + L cycles from an accepted input to out_valid (N = 3: 5; N = 1: 3; N = 4: 5). Throughput is one result per cycle when out_ready = 1.
- Global advance: en = !out_valid || out_ready. All stages, valid bits included, shift only when en = 1.
- in_ready = en, combinational from out_valid/out_ready. The input is accepted on in_valid && in_ready. Bubbles propagate as valid = 0; they are not collapsed.
- out_data/out_valid hold stable while out_valid && !out_ready.
- Rounding:
  - ROUND_MODE = 0: result = sum >>> E.
  - ROUND_MODE = 1 and E > 0: result = (sum + 2^(E-1)) >>> E, computed at SW+1 bits so there is no overflow.
  - E = 0: no shift, no rounding.
- Saturation:
  - SATURATE = 1: the shifted value is clamped to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
  - SATURATE = 0: the low D_WIDTH bits are kept.
  - If D_WIDTH >= the shifted width, the value is sign-extended and saturation is a no-op.
- Simultaneous in_valid and out_ready with a full pipe: both transfers occur in the same cycle; no loss, no duplication.
- Reset mid-stream: in-flight data is discarded. After release, the first out_valid comes only from inputs accepted after release, at the normal latency.
- Elaboration check: fatal if N < 1 or E < 0.

Decomposition:
- fixed_point_pkg (shared package) holds:
  - round_mode_e enum: RND_TRUNC = 0, RND_HALF_UP = 1.
  - constant functions for product/sum widths and saturation limits.
- One sub-module, fixed_point_round_sat: combinational round + shift + clamp, parametrised by IN_WIDTH, E, D_WIDTH, ROUND_MODE, SATURATE. It is reused by other fixed-point blocks.
- The adder tree is a generate loop inside the top.

Test Plan:
- Basic, defaults: A = (16384, 16384, 16384), B = (8192, 4096, -8192), out_ready = 1 -> out_data = 4096 (0.25), 5 cycles after acceptance.
- Saturation: A = B = (-32768 x3), i.e. sum = 3*2^30 >> 14 = 196608 -> SATURATE = 1 gives 131071; SATURATE = 0 gives -65536.
- Rounding: A = (1, 0, 0), B = (8192, 0, 0) -> 0 (truncate), 1 (half-up); A = (-1, 0, 0), same B -> -1 (truncate), 0 (half-up).
- Backpressure: stream 8 distinct vectors; drop out_ready for 3 cycles mid-stream -> all 8 results exact and in order. in_ready = 0 exactly while out_valid && !out_ready. out_data stable during the stall.
- Async reset: drop rst_n_in between clock edges with 4 results in flight -> out_valid = 0 and out_data = 0 immediately. After release, the next out_valid comes only from new inputs, at latency 5.
- Parametrisation: N = 1 -> latency 3, result = a0*b0 >>> E. N = 4 with A = B = (16384 x4) -> latency 5, result 65536.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared types and width/limit helpers for fixed-point datapath blocks
package fixed_point_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int sum_width(input int a_w, input int b_w, input int n);
    return prod_width(a_w, b_w) + tree_levels(n);
  endfunction

  // Number of live nodes at adder-tree level l (level 0 = the products).
  function automatic int level_count(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// rtl/fixed_point_round_sat.sv - combinational round, arithmetic shift and clamp/wrap to D_WIDTH
module fixed_point_round_sat
  import fixed_point_pkg::*;
#(
  parameter int IN_WIDTH   = 34,
  parameter int E          = 14,
  parameter int D_WIDTH    = 18,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic signed [IN_WIDTH-1:0] i_data,
  output logic signed [D_WIDTH-1:0]  o_data
);

  // One guard bit so the half-up increment can never overflow.
  localparam int RW = IN_WIDTH + 1;

  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_rnd;

  assign w_ext = RW'(i_data);

  if (ROUND_MODE == int'(RND_HALF_UP) && E > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (E - 1);
    assign w_rnd = w_ext + HALF;
  end else begin : g_trunc
    assign w_rnd = w_ext;
  end

  if (D_WIDTH >= RW || SATURATE == 0) begin : g_nosat
    assign o_data = D_WIDTH'(w_rnd >>> E);
  end else begin : g_sat
    localparam logic signed [D_WIDTH-1:0] MAXV = D_WIDTH'(sat_max(D_WIDTH));
    localparam logic signed [D_WIDTH-1:0] MINV = D_WIDTH'(sat_min(D_WIDTH));
    logic signed [RW-1:0]   w_shift;
    logic [RW-D_WIDTH:0]    w_hi;
    logic                   w_ovf;
    assign w_shift = w_rnd >>> E;
    assign w_hi    = w_shift[RW-1:D_WIDTH-1];
    assign w_ovf   = ~((&w_hi) | (~|w_hi));
    assign o_data  = !w_ovf ? w_shift[D_WIDTH-1:0] : (w_shift[RW-1] ? MINV : MAXV);
  end

endmodule

// File: rtl/fixed_point_stream_dot.sv
// rtl/fixed_point_stream_dot.sv - pipelined signed fixed-point N-lane dot product with valid/ready
module fixed_point_stream_dot
  import fixed_point_pkg::*;
#(
  parameter int N           = 3,
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int P_FRAC_BITS = 14,
  parameter int D_WIDTH     = 18,
  parameter int ROUND_MODE  = 0,
  parameter int SATURATE    = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*A_WIDTH-1:0]      in_a,
  input  logic [N*B_WIDTH-1:0]      in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [D_WIDTH-1:0] out_data
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);
  localparam int L  = tree_levels(N);
  localparam int SW = sum_width(A_WIDTH, B_WIDTH, N);
  localparam int E  = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;
  localparam int NV = 3 + L;

  if (N < 1 || E < 0) begin : g_param_check
    $fatal(1, "fixed_point_stream_dot: N must be >= 1 and P_FRAC_BITS <= A_FRAC_BITS + B_FRAC_BITS");
  end

  logic                      w_en;
  logic [NV-1:0]             r_vld;
  logic [N*A_WIDTH-1:0]      r_a;
  logic [N*B_WIDTH-1:0]      r_b;
  logic signed [SW-1:0]      r_tree [0:L][0:N-1];
  logic signed [D_WIDTH-1:0] w_res;
  logic signed [D_WIDTH-1:0] r_out_data;

  // Whole pipe advances in lockstep; bubbles keep their slot.
  assign w_en      = !r_vld[NV-1] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[NV-1];
  assign out_data  = r_out_data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_out_data <= '0;
    end else if (w_en) begin
      r_vld      <= {r_vld[NV-2:0], in_valid};
      r_a        <= in_a;
      r_b        <= in_b;
      r_out_data <= w_res;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_mul
    logic signed [A_WIDTH-1:0] w_a;
    logic signed [B_WIDTH-1:0] w_b;
    logic signed [PW-1:0]      w_p;
    assign w_a = r_a[i*A_WIDTH +: A_WIDTH];
    assign w_b = r_b[i*B_WIDTH +: B_WIDTH];
    assign w_p = PW'(w_a) * PW'(w_b);
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)  r_tree[0][i] <= '0;
      else if (w_en)  r_tree[0][i] <= SW'(w_p);
    end
  end

  // Sign-extended to SW from the start, so every level is lossless.
  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int PC = level_count(N, l - 1);
    for (genvar i = 0; i < N; i++) begin : g_node
      if (2 * i + 1 < PC) begin : g_add
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) r_tree[l][i] <= '0;
          else if (w_en) r_tree[l][i] <= r_tree[l-1][2*i] + r_tree[l-1][2*i+1];
        end
      end else if (2 * i < PC) begin : g_pass
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) r_tree[l][i] <= '0;
          else if (w_en) r_tree[l][i] <= r_tree[l-1][2*i];
        end
      end else begin : g_idle
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) r_tree[l][i] <= '0;
          else if (w_en) r_tree[l][i] <= '0;
        end
      end
    end
  end

  fixed_point_round_sat #(
    .IN_WIDTH  (SW),
    .E         (E),
    .D_WIDTH   (D_WIDTH),
    .ROUND_MODE(ROUND_MODE),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .i_data(r_tree[L][0]),
    .o_data(w_res)
  );

endmodule

// File: tb/tb_fixed_point_stream_dot.sv
// tb/tb_fixed_point_stream_dot.sv - scoreboard bench over five configurations of the dot product
module tb_fixed_point_stream_dot;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [47:0] a3, b3;
  logic [15:0] a1, b1;
  logic [63:0] a4, b4;
  logic ir [5];
  logic ov [5];
  logic signed [17:0] od [5];

  int va [4];
  int vb [4];
  logic signed [17:0] sb_q [5][$];
  int acc_q [5][$];
  logic prev_stall [5];
  logic signed [17:0] prev_od [5];
  longint last_out [5];
  int out_cnt [5];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit chk_lat = 1'b0;
  bit got_in0 = 1'b0;

  // 0: default, 1: wrap, 2: half-up, 3: N=1, 4: N=4
  fixed_point_stream_dot #(.N(3)) u_d0 (.clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(a3), .in_b(b3), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));
  fixed_point_stream_dot #(.N(3), .SATURATE(0)) u_d1 (.clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(a3), .in_b(b3), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));
  fixed_point_stream_dot #(.N(3), .ROUND_MODE(1)) u_d2 (.clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(a3), .in_b(b3), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));
  fixed_point_stream_dot #(.N(1)) u_d3 (.clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .in_a(a1), .in_b(b1), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]));
  fixed_point_stream_dot #(.N(4)) u_d4 (.clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
    .in_a(a4), .in_b(b4), .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [17:0] model(input int n, input bit rm, input bit sat);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    if (rm) s += 8192;
    s = s >>> 14;
    if (sat) begin
      if (s > 131071) s = 131071;
      else if (s < -131072) s = -131072;
    end
    return s[17:0];
  endfunction

  function automatic logic signed [17:0] model_for(input int d);
    case (d)
      1:       return model(3, 1'b0, 1'b0);
      2:       return model(3, 1'b1, 1'b1);
      3:       return model(1, 1'b0, 1'b1);
      4:       return model(4, 1'b0, 1'b1);
      default: return model(3, 1'b0, 1'b1);
    endcase
  endfunction

  task automatic apply_vec();
    a3 = {va[2][15:0], va[1][15:0], va[0][15:0]};
    b3 = {vb[2][15:0], vb[1][15:0], vb[0][15:0]};
    a1 = va[0][15:0];
    b1 = vb[0][15:0];
    a4 = {va[3][15:0], a3};
    b4 = {vb[3][15:0], b3};
  endtask

  task automatic set_vec(input int x0, x1, x2, x3, y0, y1, y2, y3);
    va[0] = x0; va[1] = x1; va[2] = x2; va[3] = x3;
    vb[0] = y0; vb[1] = y1; vb[2] = y2; vb[3] = y3;
    apply_vec();
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 4; i++) begin
      va[i] = int'($urandom_range(0, 65535)) - 32768;
      vb[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    apply_vec();
  endtask

  // Handshakes seen here complete on the next rising edge.
  task automatic monitor();
    got_in0 = 1'b0;
    for (int d = 0; d < 5; d++) begin
      if (prev_stall[d]) begin
        check($sformatf("stall_valid_d%0d", d), ov[d], 1);
        check($sformatf("stall_data_d%0d", d), od[d], prev_od[d]);
      end
      if (ov[d] && out_ready) begin
        check($sformatf("sb_underflow_d%0d", d), sb_q[d].size() > 0, 1);
        if (sb_q[d].size() > 0) begin
          logic signed [17:0] exp_v;
          int acc;
          exp_v = sb_q[d].pop_front();
          acc = acc_q[d].pop_front();
          check($sformatf("out_d%0d", d), od[d], exp_v);
          if (chk_lat) check($sformatf("latency_d%0d", d), cyc - acc, (d == 3) ? 3 : 5);
          last_out[d] = od[d];
          out_cnt[d]++;
        end
      end
      if (in_valid && ir[d]) begin
        sb_q[d].push_back(model_for(d));
        acc_q[d].push_back(cyc);
        if (d == 0) got_in0 = 1'b1;
      end
      prev_stall[d] = ov[d] && !out_ready;
      prev_od[d] = od[d];
    end
    check("in_ready_d0", ir[0], !(ov[0] && !out_ready));
  endtask

  task automatic step();
    #1;
    monitor();
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic send1();
    for (int d = 0; d < 5; d++) last_out[d] = 999999;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    for (int d = 0; d < 5; d++) check($sformatf("drain_d%0d", d), sb_q[d].size(), 0);
  endtask

  initial begin
    int base;
    int k;
    for (int d = 0; d < 5; d++) begin
      prev_stall[d] = 1'b0;
      prev_od[d] = '0;
      last_out[d] = 0;
      out_cnt[d] = 0;
    end
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      check($sformatf("reset_valid_d%0d", d), ov[d], 0);
      check($sformatf("reset_data_d%0d", d), od[d], 0);
    end
    rst_n = 1'b1;

    chk_lat = 1'b1;
    set_vec(16384, 16384, 16384, 0, 8192, 4096, -8192, 0);
    send1();
    drain();
    check("basic_d0", last_out[0], 4096);
    check("basic_n1", last_out[3], 8192);

    set_vec(-32768, -32768, -32768, 0, -32768, -32768, -32768, 0);
    send1();
    drain();
    check("sat_clamp", last_out[0], 131071);
    check("sat_wrap", last_out[1], -65536);

    set_vec(1, 0, 0, 0, 8192, 0, 0, 0);
    send1();
    drain();
    check("rnd_pos_trunc", last_out[0], 0);
    check("rnd_pos_halfup", last_out[2], 1);

    set_vec(-1, 0, 0, 0, 8192, 0, 0, 0);
    send1();
    drain();
    check("rnd_neg_trunc", last_out[0], -1);
    check("rnd_neg_halfup", last_out[2], 0);

    set_vec(16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384);
    send1();
    drain();
    check("n4_result", last_out[4], 65536);

    chk_lat = 1'b0;
    base = out_cnt[0];
    k = 0;
    rand_vec();
    for (int t = 0; t < 60 && k < 8; t++) begin
      out_ready = !(t >= 5 && t < 8);
      in_valid = 1'b1;
      step();
      if (got_in0) begin
        k++;
        rand_vec();
      end
    end
    drain();
    check("bp_results", out_cnt[0] - base, 8);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("rst_pre_valid", ov[0], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 5; d++) begin
      check($sformatf("async_rst_valid_d%0d", d), ov[d], 0);
      check($sformatf("async_rst_data_d%0d", d), od[d], 0);
      sb_q[d].delete();
      acc_q[d].delete();
      prev_stall[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step();
    chk_lat = 1'b1;
    set_vec(16384, 16384, 16384, 0, 8192, 4096, -8192, 0);
    send1();
    drain();
    check("post_rst_d0", last_out[0], 4096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
